// File: rtl/cell_bist_ctrl.sv
// Built-in self-test controller: a Galois LFSR drives STIM and a MISR compacts RESP into SIG, which is compared with GOLDEN.
// Latency: DONE rises NPAT+LAT edges after START is accepted (NPAT==0 goes straight to DONE).
// Backpressure: none; START is ignored while BUSY. Optional scan-out is enabled by defining CELL_BIST_SHIFT_EN.
module cell_bist_ctrl #(
  parameter int unsigned     W     = 16,
  parameter int unsigned     CNT_W = 16,
  parameter logic [W-1:0]    SEED  = 16'hACE1,
  parameter logic [W-1:0]    POLY  = 16'hB400,
  parameter int unsigned     LAT   = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [CNT_W-1:0] NPAT,
  input  logic [W-1:0]     GOLDEN,
  input  logic [W-1:0]     RESP,
  output logic [W-1:0]     STIM,
  output logic [W-1:0]     SIG,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS
`ifdef CELL_BIST_SHIFT_EN
  ,
  input  logic             SHIFT,
  output logic             SO
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  // Index of the final FLUSH cycle; unused when LAT is 0.
  localparam logic [1:0] FLUSH_LAST = (LAT > 0) ? 2'(LAT - 1) : 2'd0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, npat_q;
  logic [1:0]       flush_cnt;
  logic [W-1:0]     stim_q, sig_q, sig_nxt;
  logic             pass_q;
  logic             start_acc, run, enter_done, vld_tap;
`ifdef CELL_BIST_SHIFT_EN
  logic             shift_acc;
`endif

  // Shared Galois step used by both the LFSR and the MISR.
  function automatic logic [W-1:0] step(input logic [W-1:0] x);
    return (x >> 1) ^ (x[0] ? POLY : '0);
  endfunction

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    run       = 1'b0;
`ifdef CELL_BIST_SHIFT_EN
    shift_acc = 1'b0;
`endif
    case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          start_acc = 1'b1;
          state_nxt = (NPAT == '0) ? S_DONE : S_RUN;
        end
`ifdef CELL_BIST_SHIFT_EN
        else if (SHIFT) begin
          shift_acc = 1'b1;
        end
`endif
      end
      S_RUN: begin
        run = 1'b1;
        // cnt counts completed patterns, so the last one is at NPAT-1.
        if (cnt == npat_q - CNT_W'(1)) state_nxt = (LAT > 0) ? S_FLUSH : S_DONE;
      end
      S_FLUSH: begin
        if (flush_cnt == FLUSH_LAST) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A restart with NPAT==0 from DONE re-evaluates PASS too.
    enter_done = (state_nxt == S_DONE) && ((state != S_DONE) || start_acc);
  end

  // Response-valid pipeline: the RUN flag delayed to line up with the array's latency.
  generate
    if (LAT == 0) begin : g_nolat
      assign vld_tap = run;
    end else begin : g_lat
      logic [LAT-1:0] dly_q;
      // Shift the RUN flag through LAT stages.
      always_ff @(posedge CLK) begin
        if (RST) begin
          dly_q <= '0;
        end else begin
          dly_q[0] <= run;
          for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign vld_tap = dly_q[LAT-1];
    end
  endgenerate

  // Signature value after this edge; also feeds the PASS compare on entry to DONE.
  always_comb begin
    sig_nxt = sig_q;
    if (start_acc)     sig_nxt = '0;
    else if (vld_tap)  sig_nxt = step(sig_q) ^ RESP;
`ifdef CELL_BIST_SHIFT_EN
    else if (shift_acc) sig_nxt = {sig_q[0], sig_q[W-1:1]};
`endif
  end

  // Datapath: LFSR, MISR, pattern/flush counters and the PASS flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stim_q    <= SEED;
      sig_q     <= '0;
      cnt       <= '0;
      npat_q    <= '0;
      flush_cnt <= '0;
      pass_q    <= 1'b0;
    end else begin
      sig_q     <= sig_nxt;
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + 2'd1 : 2'd0;
      if (start_acc) begin
        stim_q <= SEED;
        cnt    <= '0;
        npat_q <= NPAT;
      end else if (run) begin
        stim_q <= step(stim_q);
        cnt    <= cnt + CNT_W'(1);
      end
      if (enter_done)     pass_q <= (sig_nxt == GOLDEN);
      else if (start_acc) pass_q <= 1'b0;
    end
  end

  assign STIM = stim_q;
  assign SIG  = sig_q;
  assign PASS = pass_q;
  assign BUSY = (state == S_RUN) || (state == S_FLUSH);
  assign DONE = (state == S_DONE);
`ifdef CELL_BIST_SHIFT_EN
  assign SO   = sig_q[0];
`endif

endmodule
